// File: rtl/multiplier_comb.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_comb
// Description : Unsigned N x N combinational multiplier. The product comes
//               from an AND-gate partial-product array, a carry-save
//               full-adder reduction and a ripple carry-propagate adder.
//               A registered copy of the product is provided on m_q.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_comb #(
    parameter int N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   m,
    output logic [2*N-1:0]   m_q
);

    localparam int W = 2 * N;

    logic [W-1:0] w_pp  [N];
    logic [W-1:0] w_sum [1:N-1];
    logic [W-1:0] w_cry [1:N-1];
    logic [W-1:0] w_cpa_cy;
    logic [W-1:0] w_prod;
    logic [W-1:0] r_m_q;

    // Row i holds a gated by b[i], shifted into place within the 2N-bit frame.
    generate
        for (genvar i = 0; i < N; i++) begin : g_pp
            assign w_pp[i] = {{N{1'b0}}, (a & {N{b[i]}})} << i;
        end
    endgenerate

    // Stage 1 simply pairs the first two rows; every later stage folds in one
    // more row with a column of full adders, keeping a redundant sum/carry pair.
    assign w_sum[1] = w_pp[0];
    assign w_cry[1] = w_pp[1];

    generate
        for (genvar k = 2; k < N; k++) begin : g_csa_stage
            assign w_cry[k][0] = 1'b0;
            for (genvar j = 0; j < W; j++) begin : g_csa_bit
                assign w_sum[k][j] = w_sum[k-1][j] ^ w_cry[k-1][j] ^ w_pp[k][j];
                // Carry out of the top column is always zero for an exact
                // 2N-bit product, so it is not generated.
                if (j < W - 1) begin : g_csa_carry
                    assign w_cry[k][j+1] = (w_sum[k-1][j] & w_cry[k-1][j])
                                         | (w_sum[k-1][j] & w_pp[k][j])
                                         | (w_cry[k-1][j] & w_pp[k][j]);
                end
            end
        end
    endgenerate

    assign w_cpa_cy[0] = 1'b0;

    generate
        for (genvar j = 0; j < W; j++) begin : g_cpa
            assign w_prod[j] = w_sum[N-1][j] ^ w_cry[N-1][j] ^ w_cpa_cy[j];
            if (j < W - 1) begin : g_cpa_carry
                assign w_cpa_cy[j+1] = (w_sum[N-1][j] & w_cry[N-1][j])
                                     | (w_sum[N-1][j] & w_cpa_cy[j])
                                     | (w_cry[N-1][j] & w_cpa_cy[j]);
            end
        end
    endgenerate

    assign m = w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_q <= '0;
        end else begin
            r_m_q <= w_prod;
        end
    end

    assign m_q = r_m_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_comb.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_comb
// Description : Self-checking bench for multiplier_comb at N=32, 4 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_comb;

    logic        clk;
    logic        rst;
    logic [31:0] a32, b32;
    logic [63:0] m32, mq32;
    logic [3:0]  a4, b4;
    logic [7:0]  m4, mq4;
    logic [7:0]  a8, b8;
    logic [15:0] m8, mq8;

    int n_vec;
    int n_err;

    multiplier_comb #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .a(a32), .b(b32), .m(m32), .m_q(mq32));
    multiplier_comb #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .a(a4),  .b(b4),  .m(m4),  .m_q(mq4));
    multiplier_comb #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .m(m8),  .m_q(mq8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul32(input logic [31:0] x, input logic [31:0] y);
        longint unsigned px, py;
        px = longint'(x);
        py = longint'(y);
        return 64'(px * py);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a32 = 32'd7; b32 = 32'd9;
        #3;
        n_vec++;
        if (mq32 !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mq got=%h want=%h", mq32, 64'd0);
        end
        #28;
        n_vec++;
        if (m32 !== 64'd63) begin
            n_err++;
            $display("FAIL reset_m_live got=%h want=%h", m32, 64'd63);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic [63:0] te [6];
        ta[0] = 32'h0;        tb[0] = 32'hFFFFFFFF; te[0] = 64'h0;
        ta[1] = 32'h12345678; tb[1] = 32'h0;        te[1] = 64'h0;
        ta[2] = 32'h1;        tb[2] = 32'hDEADBEEF; te[2] = 64'h00000000DEADBEEF;
        ta[3] = 32'hFFFFFFFF; tb[3] = 32'hFFFFFFFF; te[3] = 64'hFFFFFFFE00000001;
        ta[4] = 32'h80000000; tb[4] = 32'h80000000; te[4] = 64'h4000000000000000;
        ta[5] = 32'hFFFFFFFF; tb[5] = 32'h1;        te[5] = 64'h00000000FFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            a32 = ta[i]; b32 = tb[i];
            #31;
            n_vec++;
            if (m32 !== te[i]) begin
                n_err++;
                $display("FAIL directed_%0d a=%h b=%h got=%h want=%h", i, ta[i], tb[i], m32, te[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] exp;
        for (int i = 0; i < 512; i++) begin
            a32 = $urandom; b32 = $urandom;
            #31;
            exp = ref_mul32(a32, b32);
            n_vec++;
            if (m32 !== exp) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h got=%h want=%h", i, a32, b32, m32, exp);
            end
        end
    endtask

    task automatic test_registered();
        logic [31:0] pa, pb;
        rst = 1'b1;
        #1;
        n_vec++;
        if (mq32 !== 64'd0) begin
            n_err++;
            $display("FAIL reg_rst_hold got=%h want=%h", mq32, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        a32 = 32'd3; b32 = 32'd5;
        #1;
        n_vec++;
        if (mq32 !== 64'd0) begin
            n_err++;
            $display("FAIL reg_before_edge got=%h want=%h", mq32, 64'd0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (mq32 !== 64'd15) begin
            n_err++;
            $display("FAIL reg_first_edge got=%h want=%h", mq32, 64'd15);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (mq32 !== 64'd0) begin
            n_err++;
            $display("FAIL reg_async_rst got=%h want=%h", mq32, 64'd0);
        end
        n_vec++;
        if (m32 !== 64'd15) begin
            n_err++;
            $display("FAIL reg_m_during_rst got=%h want=%h", m32, 64'd15);
        end
        @(negedge clk);
        rst = 1'b0;
        // m_q must track the previous cycle's product back to back.
        for (int i = 0; i < 8; i++) begin
            pa = $urandom; pb = $urandom;
            a32 = pa; b32 = pb;
            @(posedge clk);
            #1;
            a32 = $urandom; b32 = $urandom;
            n_vec++;
            if (mq32 !== ref_mul32(pa, pb)) begin
                n_err++;
                $display("FAIL reg_track_%0d got=%h want=%h", i, mq32, ref_mul32(pa, pb));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exhaustive4();
        int exp;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a4 = 4'(x); b4 = 4'(y);
                #1;
                exp = x * y;
                n_vec++;
                if (m4 !== 8'(exp)) begin
                    n_err++;
                    $display("FAIL n4 a=%0d b=%0d got=%0d want=%0d", x, y, m4, exp);
                end
            end
        end
    endtask

    task automatic test_exhaustive8();
        int exp;
        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 256; y++) begin
                a8 = 8'(x); b8 = 8'(y);
                #1;
                exp = x * y;
                n_vec++;
                if (m8 !== 16'(exp)) begin
                    n_err++;
                    $display("FAIL n8 a=%0d b=%0d got=%0d want=%0d", x, y, m8, exp);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        a32 = '0; b32 = '0;
        a4 = '0;  b4 = '0;
        a8 = '0;  b8 = '0;
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random();
        test_registered();
        test_exhaustive4();
        test_exhaustive8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplier_comb.md
MULTIPLIER_COMB -- requirements
Module: multiplier_comb

Interface
REQ-001 Parameter: N, default 32, operand width in bits; the block SHALL support any N >= 2.
REQ-002 Port: clk, input, 1, single clock; it drives only the registered product copy.
REQ-003 Port: rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port: a, input, N, unsigned multiplicand.
REQ-005 Port: b, input, N, unsigned multiplier.
REQ-006 Port: m, output, 2N, combinational unsigned product a*b.
REQ-007 Port: m_q, output, 2N, product registered on the clk rising edge.

Function
REQ-008 m SHALL equal a*b, both operands unsigned, exact in 2N bits; no truncation, no overflow possible.
REQ-009 m SHALL be purely combinational: zero cycle latency, no dependence on clk or rst, settling within one propagation delay of any change on a or b.
REQ-010 m SHALL remain correct when clk and rst are left unconnected or held at any constant value.
REQ-011 The product SHALL be built structurally, without the HDL multiply operator:
- N x N AND-gate partial-product array;
- carry-save (full/half-adder tree) reduction to two rows;
- final 2N-bit carry-propagate adder.
REQ-012 Partial product row i SHALL be (a AND b[i]) shifted left by i, zero-extended to 2N bits.
REQ-013 The reduction tree SHALL be generated from N using generate loops, so any legal N elaborates without code edits.
REQ-014 The logic SHALL contain no latches and no combinational loops; the result SHALL be free of X/Z whenever a and b are known.
REQ-015 m_q SHALL load m on every clk rising edge while rst is low, giving 1-cycle latency relative to m.
REQ-016 Boundary behaviour:
- a=0 or b=0 SHALL give m=0;
- a=1 SHALL give m=b;
- a=b=2^N-1 SHALL give m=2^(2N)-2^(N+1)+1, with no carry out of bit 2N-1.

Reset
REQ-017 While rst is high, m_q SHALL be 0, taking effect immediately and independent of clk.
REQ-018 After rst is released, m_q SHALL update at the first clk rising edge.
REQ-019 rst SHALL NOT affect m at any time, including when rst is asserted mid-operation.

Verification
REQ-020 The bench SHALL cover at least these scenarios (N=32, each operand pair applied, then checked after at least 31 ns settling):
- Zero: a=0, b=0xFFFFFFFF -> m=0; then a=0x12345678, b=0 -> m=0.
- Identity: a=1, b=0xDEADBEEF -> m=0x00000000DEADBEEF.
- Maximum: a=b=0xFFFFFFFF -> m=0xFFFFFFFE00000001.
- Powers of two: a=0x80000000, b=0x80000000 -> m=0x4000000000000000.
- Random: 512 pairs drawn with $urandom, each checked against a*b with case inequality (!==); there SHALL be zero mismatches and no X/Z on m.
- Registered path: assert rst -> m_q=0 immediately; release rst, apply a=3, b=5, one clk edge -> m_q=15; reassert rst between edges -> m_q=0 at once while m stays 15.
REQ-021 The bench SHALL also elaborate N=4 and N=8 and check them exhaustively: every a,b pair -> m=a*b.
